ct_ciu_ncq_gm_multi: RTL and testbench
======================================

Name: ct_ciu_ncq_gm_multi

Overview:
- Multi-entry global exclusive monitor for the CIU non-cacheable queue; supersedes the single-entry monitor.
- Tracks up to ENTRY_NUM outstanding exclusive reservations, one per requester ID, at a configurable address granule.
- Sets reservations on exclusive-read pop, clears them on writes to the monitored granule, and reports exclusive-write success in the same cycle.
- Sits between RAQ/WAQ pop logic and the AW response path.

Parameters:
ENTRY_NUM, 4, number of monitor entries (2..16)
ADDRW, 40, physical address width
IDW, 8, requester ID width (core/thread tag)
GRAN_LSB, 6, address bits [GRAN_LSB-1:0] ignored in all compares (64B granule)
TIMEOUT_W, 10, width of per-entry timeout counter (optional feature only)

Ports:
forever_cpuclk  in  1  free-running clock
cpurst_b  in  1  asynchronous active-low reset
ciu_icg_en  in  1  module clock-gate enable for payload registers
pad_yy_icg_scan_en  in  1  scan clock-gate bypass
gm_set_vld  in  1  exclusive read popped from RAQ
gm_set_addr  in  ADDRW  exclusive read address
gm_set_id  in  IDW  exclusive read requester ID
gm_wr_vld  in  1  write popped from WAQ (any type)
gm_wr_excl  in  1  popped write is exclusive
gm_wr_addr  in  ADDRW  write address
gm_wr_id  in  IDW  write requester ID
gm_wr_success  out  1  exclusive write passes (combinational, same cycle)
gm_entry_vld  out  ENTRY_NUM  per-entry valid
gm_evict  out  1  pulse: set caused eviction of a valid entry of another ID

Behaviour:
- Reset: all entry valids 0, addr/ID payloads 0, round-robin pointer 0, gm_evict 0; gm_wr_success 0 while inputs idle.
- Granule compare: gaddr = addr[ADDRW-1:GRAN_LSB] for all matches.
- gm_wr_success = gm_wr_vld & gm_wr_excl & (some valid entry has id==gm_wr_id and gaddr==gaddr(gm_wr_addr)).
- Clear (registered, next edge): gm_wr_vld and (exclusive success OR non-exclusive write) -> invalidate every valid entry whose gaddr matches, regardless of ID. Failed exclusive write -> no state change.
- Set (next edge), gm_set_vld: target entry chosen by priority:
  1. valid entry with id==gm_set_id (overwrite; one reservation per ID);
  2. else lowest-index invalid entry;
  3. else entry at round-robin pointer; gm_evict=1 that cycle (registered pulse, 1 cycle); pointer advances by 1, wrapping ENTRY_NUM-1 -> 0.
- Pointer advances only on eviction.
- Simultaneous set and clear:
  - clear evaluated on pre-edge state;
  - if set gaddr == clearing write gaddr, the set is dropped (clear priority) and no entry, pointer or evict change occurs;
  - otherwise both apply, and the set target selection uses post-clear valids (an entry freed by the clear is eligible as invalid).
- Set with same ID and same granule as existing entry: entry stays valid, payload rewritten (idempotent).
- Payload regs clocked by gated_clk_cell: clk_in forever_cpuclk, local_en gm_set_vld, module_en ciu_icg_en, global_en 1, external_en 0. Valids and pointer on forever_cpuclk.
- Reset asserted mid-operation: all valids drop immediately; first write after reset must report fail.

Optional Feature:
CT_CIU_GM_TIMEOUT_EN
- Defined: each entry has a TIMEOUT_W-bit counter, loaded with 0 on set and incremented each cycle while valid. On reaching all-ones the entry invalidates at the next edge. A set to the same entry in that cycle wins and reloads the counter. Guarantees forward progress for abandoned reservations.
- Undefined: no counters; entries persist until cleared or evicted.

Test Plan:
- Set id=3 addr=0x80_0000_1040; next cycle excl write id=3 addr=0x80_0000_1078 -> gm_wr_success=1, entry0 invalid after edge.
- Set id=1 addr A; non-excl write id=2 to A+0x8 -> entry cleared; later excl write id=1 to A -> success=0.
- ENTRY_NUM=4: sets ids 0..3 to distinct addrs, then set id=7 -> entry0 replaced, gm_evict=1 one cycle, pointer=1; next overflow set replaces entry1.
- Same cycle: set id=5 addr B and non-excl write to B -> set dropped, gm_entry_vld unchanged; with write to C != B -> set lands in a free entry.
- Failed excl write id=4 addr A while id=2 holds A -> success=0, id=2 entry stays valid.
- TIMEOUT_EN, TIMEOUT_W=4: set, idle 15 cycles -> entry invalid at cycle 16; excl write -> success=0.

Source files
------------

// File: rtl/ct_ciu_ncq_gm_multi.sv
// ct_ciu_ncq_gm_multi -- multi-entry global exclusive monitor for the CIU
// non-cacheable queue. Each entry holds one exclusive reservation
// (requester ID + address granule).
//   - A set reserves an entry when an exclusive read pops from the RAQ.
//   - A write popped from the WAQ clears every entry in its granule.
//   - An exclusive write reports pass or fail combinationally, in the same cycle.
//
// Optional build macro: CT_CIU_GM_TIMEOUT_EN adds a per-entry age counter.
// When the counter reaches all-ones, the entry drops its reservation.
//
// Ports:
//   forever_cpuclk       free-running clock
//   cpurst_b             asynchronous active-low reset
//   ciu_icg_en           module clock-gate enable for payload registers
//   pad_yy_icg_scan_en   scan clock-gate bypass
//   gm_set_vld/addr/id   exclusive read popped from RAQ
//   gm_wr_vld/excl/addr/id  write popped from WAQ
//   gm_wr_success        exclusive write passes (same cycle)
//   gm_entry_vld         per-entry valid
//   gm_evict             1-cycle pulse: a set displaced another ID's entry

// Latch-based clock gate used for the payload registers.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);
  logic clk_en_bf_latch;
  logic clk_en_lat;

  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  always_latch begin
    if (!clk_in) clk_en_lat = clk_en_bf_latch | pad_yy_icg_scan_en;
  end

  assign clk_out = clk_in & clk_en_lat;
endmodule

module ct_ciu_ncq_gm_multi #(
  parameter int ENTRY_NUM = 4,
  parameter int ADDRW     = 40,
  parameter int IDW       = 8,
  parameter int GRAN_LSB  = 6,
  parameter int TIMEOUT_W = 10
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 ciu_icg_en,
  input  logic                 pad_yy_icg_scan_en,
  input  logic                 gm_set_vld,
  input  logic [ADDRW-1:0]     gm_set_addr,
  input  logic [IDW-1:0]       gm_set_id,
  input  logic                 gm_wr_vld,
  input  logic                 gm_wr_excl,
  input  logic [ADDRW-1:0]     gm_wr_addr,
  input  logic [IDW-1:0]       gm_wr_id,
  output logic                 gm_wr_success,
  output logic [ENTRY_NUM-1:0] gm_entry_vld,
  output logic                 gm_evict
);
  localparam int GW   = ADDRW - GRAN_LSB;
  localparam int PTRW = $clog2(ENTRY_NUM);

  logic [ENTRY_NUM-1:0] vld_q;
  logic [GW-1:0]        ga_q [ENTRY_NUM];
  logic [IDW-1:0]       id_q [ENTRY_NUM];
  logic [PTRW-1:0]      ptr_q;
  logic                 evict_q;

  logic [GW-1:0]        set_ga;
  logic [GW-1:0]        wr_ga;
  logic [ENTRY_NUM-1:0] wr_hit;
  logic [ENTRY_NUM-1:0] clr_mask;
  logic [ENTRY_NUM-1:0] vld_pc;
  logic [ENTRY_NUM-1:0] id_match;
  logic [ENTRY_NUM-1:0] tgt_oh;
  logic [ENTRY_NUM-1:0] expire;
  logic [PTRW-1:0]      free_idx;
  logic                 any_free;
  logic                 clr_en;
  logic                 set_go;
  logic                 evict_nxt;
  logic                 gm_clk;
  logic                 unused_ok;

  assign set_ga = gm_set_addr[ADDRW-1:GRAN_LSB];
  assign wr_ga  = gm_wr_addr[ADDRW-1:GRAN_LSB];

  always_comb begin
    wr_hit   = '0;
    clr_mask = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      wr_hit[i]   = vld_q[i] & (id_q[i] == gm_wr_id) & (ga_q[i] == wr_ga);
      clr_mask[i] = vld_q[i] & (ga_q[i] == wr_ga);
    end
  end

  assign gm_wr_success = gm_wr_vld & gm_wr_excl & (|wr_hit);

  // A failed exclusive write leaves the monitor untouched.
  assign clr_en = gm_wr_vld & (~gm_wr_excl | gm_wr_success);
  assign vld_pc = clr_en ? (vld_q & ~clr_mask) : vld_q;

  // A set to the granule being cleared this cycle loses to the clear.
  assign set_go = gm_set_vld & ~(clr_en & (set_ga == wr_ga));

  // Target selection works on the post-clear valids, so an entry freed
  // in this cycle is eligible as invalid.
  always_comb begin
    id_match  = '0;
    free_idx  = '0;
    any_free  = 1'b0;
    tgt_oh    = '0;
    evict_nxt = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      id_match[i] = vld_pc[i] & (id_q[i] == gm_set_id);
    end
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!vld_pc[i]) begin
        free_idx = PTRW'(i);
        any_free = 1'b1;
      end
    end
    if (set_go) begin
      if (|id_match) begin
        tgt_oh = id_match;
      end else if (any_free) begin
        tgt_oh = ENTRY_NUM'(1) << free_idx;
      end else begin
        tgt_oh    = ENTRY_NUM'(1) << ptr_q;
        evict_nxt = 1'b1;
      end
    end
  end

`ifdef CT_CIU_GM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q [ENTRY_NUM];

  always_comb begin
    expire = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      expire[i] = vld_q[i] & (&cnt_q[i]);
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < ENTRY_NUM; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (tgt_oh[i])     cnt_q[i] <= '0;
        else if (vld_q[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end
`else
  assign expire = '0;
`endif

  // A set targeting an expiring entry re-validates it, because tgt_oh is ORed in last.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld_q   <= '0;
      ptr_q   <= '0;
      evict_q <= 1'b0;
    end else begin
      vld_q   <= (vld_pc & ~expire) | tgt_oh;
      evict_q <= evict_nxt;
      if (evict_nxt) begin
        ptr_q <= (ptr_q == PTRW'(ENTRY_NUM - 1)) ? '0 : ptr_q + 1'b1;
      end
    end
  end

  gated_clk_cell x_gm_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (1'b1),
    .module_en          (ciu_icg_en),
    .local_en           (gm_set_vld),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (gm_clk)
  );

  always_ff @(posedge gm_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        ga_q[i] <= '0;
        id_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (tgt_oh[i]) begin
          ga_q[i] <= set_ga;
          id_q[i] <= gm_set_id;
        end
      end
    end
  end

  assign gm_entry_vld = vld_q;
  assign gm_evict     = evict_q;

  // The offset bits inside a granule never take part in a compare.
  assign unused_ok = ^{gm_set_addr[GRAN_LSB-1:0], gm_wr_addr[GRAN_LSB-1:0]} ^ (TIMEOUT_W > 0);
endmodule

// File: tb/tb_ct_ciu_ncq_gm_multi.sv
// Directed bench for ct_ciu_ncq_gm_multi with default parameters
// (ENTRY_NUM=4, ADDRW=40, IDW=8, 64B granule, timeout feature off).
module tb_ct_ciu_ncq_gm_multi;
  logic        clk;
  logic        rst_b;
  logic        icg_en;
  logic        scan_en;
  logic        set_vld;
  logic [39:0] set_addr;
  logic [7:0]  set_id;
  logic        wr_vld;
  logic        wr_excl;
  logic [39:0] wr_addr;
  logic [7:0]  wr_id;
  logic        wr_success;
  logic [3:0]  entry_vld;
  logic        evict;

  int checks = 0;
  int errors = 0;
  logic succ_s;

  ct_ciu_ncq_gm_multi dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_b),
    .ciu_icg_en         (icg_en),
    .pad_yy_icg_scan_en (scan_en),
    .gm_set_vld         (set_vld),
    .gm_set_addr        (set_addr),
    .gm_set_id          (set_id),
    .gm_wr_vld          (wr_vld),
    .gm_wr_excl         (wr_excl),
    .gm_wr_addr         (wr_addr),
    .gm_wr_id           (wr_id),
    .gm_wr_success      (wr_success),
    .gm_entry_vld       (entry_vld),
    .gm_evict           (evict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of activity: inputs applied at negedge, success sampled
  // before the posedge into succ_s, state visible #1 after the posedge.
  task automatic cyc(input logic sv, input logic [39:0] sa, input logic [7:0] si,
                     input logic wv, input logic we, input logic [39:0] wa,
                     input logic [7:0] wi);
    @(negedge clk);
    set_vld = sv; set_addr = sa; set_id = si;
    wr_vld = wv; wr_excl = we; wr_addr = wa; wr_id = wi;
    #2 succ_s = wr_success;
    @(posedge clk);
    #1;
    set_vld = 1'b0; wr_vld = 1'b0; wr_excl = 1'b0;
    set_addr = '0; set_id = '0; wr_addr = '0; wr_id = '0;
  endtask

  task automatic do_set(input logic [39:0] a, input logic [7:0] id);
    cyc(1'b1, a, id, 1'b0, 1'b0, 40'h0, 8'h0);
  endtask

  task automatic do_wr(input logic excl, input logic [39:0] a, input logic [7:0] id);
    cyc(1'b0, 40'h0, 8'h0, 1'b1, excl, a, id);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (entry_vld !== 4'b0000) begin
      errors++; $display("FAIL reset_vld: got %b exp %b", entry_vld, 4'b0000);
    end
    checks++;
    if (evict !== 1'b0) begin
      errors++; $display("FAIL reset_evict: got %b exp 0", evict);
    end
    checks++;
    if (wr_success !== 1'b0) begin
      errors++; $display("FAIL reset_success: got %b exp 0", wr_success);
    end
  endtask

  task automatic test_excl_success();
    do_reset();
    do_set(40'h80_0000_1040, 8'd3);
    checks++;
    if (entry_vld !== 4'b0001) begin
      errors++; $display("FAIL set_vld: got %b exp %b", entry_vld, 4'b0001);
    end
    // Next granule up: same ID but a different granule, so it must fail.
    do_wr(1'b1, 40'h80_0000_1080, 8'd3);
    checks++;
    if (succ_s !== 1'b0) begin
      errors++; $display("FAIL gran_boundary_succ: got %b exp 0", succ_s);
    end
    checks++;
    if (entry_vld !== 4'b0001) begin
      errors++; $display("FAIL gran_boundary_vld: got %b exp %b", entry_vld, 4'b0001);
    end
    do_wr(1'b1, 40'h80_0000_1078, 8'd3);
    checks++;
    if (succ_s !== 1'b1) begin
      errors++; $display("FAIL excl_succ: got %b exp 1", succ_s);
    end
    checks++;
    if (entry_vld !== 4'b0000) begin
      errors++; $display("FAIL excl_clear: got %b exp %b", entry_vld, 4'b0000);
    end
  endtask

  task automatic test_nonexcl_clear();
    do_reset();
    do_set(40'h10_0000_2000, 8'd1);
    do_wr(1'b0, 40'h10_0000_2008, 8'd2);
    checks++;
    if (succ_s !== 1'b0) begin
      errors++; $display("FAIL nonexcl_succ: got %b exp 0", succ_s);
    end
    checks++;
    if (entry_vld !== 4'b0000) begin
      errors++; $display("FAIL nonexcl_clear: got %b exp %b", entry_vld, 4'b0000);
    end
    do_wr(1'b1, 40'h10_0000_2000, 8'd1);
    checks++;
    if (succ_s !== 1'b0) begin
      errors++; $display("FAIL after_clear_succ: got %b exp 0", succ_s);
    end
  endtask

  task automatic test_failed_excl();
    do_reset();
    do_set(40'h20_0000_3000, 8'd2);
    do_wr(1'b1, 40'h20_0000_3000, 8'd4);
    checks++;
    if (succ_s !== 1'b0) begin
      errors++; $display("FAIL wrong_id_succ: got %b exp 0", succ_s);
    end
    checks++;
    if (entry_vld !== 4'b0001) begin
      errors++; $display("FAIL wrong_id_keep: got %b exp %b", entry_vld, 4'b0001);
    end
  endtask

  task automatic test_id_overwrite();
    do_reset();
    do_set(40'h1000, 8'd5);
    do_set(40'h2000, 8'd6);
    do_set(40'h7000, 8'd5);
    checks++;
    if (entry_vld !== 4'b0011 || evict !== 1'b0) begin
      errors++; $display("FAIL id_overwrite: got vld %b evict %b exp 0011 0", entry_vld, evict);
    end
    do_wr(1'b1, 40'h1000, 8'd5);
    checks++;
    if (succ_s !== 1'b0) begin
      errors++; $display("FAIL old_gran_succ: got %b exp 0", succ_s);
    end
    do_wr(1'b1, 40'h7000, 8'd5);
    checks++;
    if (succ_s !== 1'b1 || entry_vld !== 4'b0010) begin
      errors++; $display("FAIL new_gran: got succ %b vld %b exp 1 0010", succ_s, entry_vld);
    end
  endtask

  task automatic test_evict();
    logic [39:0] addrs [4];
    addrs[0] = 40'h1000; addrs[1] = 40'h2000; addrs[2] = 40'h3000; addrs[3] = 40'h4000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_set(addrs[i], 8'(i));
      checks++;
      if (evict !== 1'b0) begin
        errors++; $display("FAIL fill_evict_%0d: got %b exp 0", i, evict);
      end
    end
    checks++;
    if (entry_vld !== 4'b1111) begin
      errors++; $display("FAIL fill_vld: got %b exp 1111", entry_vld);
    end
    do_set(40'h5000, 8'd7);
    checks++;
    if (evict !== 1'b1) begin
      errors++; $display("FAIL evict_pulse: got %b exp 1", evict);
    end
    do_wr(1'b1, 40'h1000, 8'd0);
    checks++;
    if (succ_s !== 1'b0 || evict !== 1'b0) begin
      errors++; $display("FAIL evicted_id0: got succ %b evict %b exp 0 0", succ_s, evict);
    end
    do_set(40'h6000, 8'd8);
    checks++;
    if (evict !== 1'b1) begin
      errors++; $display("FAIL evict2_pulse: got %b exp 1", evict);
    end
    do_wr(1'b1, 40'h2000, 8'd1);
    checks++;
    if (succ_s !== 1'b0) begin
      errors++; $display("FAIL evicted_id1: got %b exp 0", succ_s);
    end
    do_wr(1'b1, 40'h3000, 8'd2);
    checks++;
    if (succ_s !== 1'b1 || entry_vld !== 4'b1011) begin
      errors++; $display("FAIL id2_kept: got succ %b vld %b exp 1 1011", succ_s, entry_vld);
    end
    do_wr(1'b1, 40'h5000, 8'd7);
    checks++;
    if (succ_s !== 1'b1 || entry_vld !== 4'b1010) begin
      errors++; $display("FAIL id7_in_e0: got succ %b vld %b exp 1 1010", succ_s, entry_vld);
    end
    do_wr(1'b1, 40'h6000, 8'd8);
    checks++;
    if (succ_s !== 1'b1 || entry_vld !== 4'b1000) begin
      errors++; $display("FAIL id8_in_e1: got succ %b vld %b exp 1 1000", succ_s, entry_vld);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    cyc(1'b1, 40'h9000, 8'd5, 1'b1, 1'b0, 40'h9010, 8'd9);
    checks++;
    if (entry_vld !== 4'b0000 || evict !== 1'b0) begin
      errors++; $display("FAIL set_dropped: got vld %b evict %b exp 0000 0", entry_vld, evict);
    end
    do_set(40'hA000, 8'd1);
    do_set(40'hB000, 8'd2);
    do_set(40'hC000, 8'd3);
    do_set(40'hD000, 8'd4);
    cyc(1'b1, 40'h9000, 8'd5, 1'b1, 1'b0, 40'hB000, 8'd9);
    checks++;
    if (entry_vld !== 4'b1111 || evict !== 1'b0) begin
      errors++; $display("FAIL set_into_freed: got vld %b evict %b exp 1111 0", entry_vld, evict);
    end
    do_wr(1'b1, 40'hB000, 8'd2);
    checks++;
    if (succ_s !== 1'b0) begin
      errors++; $display("FAIL cleared_id2: got %b exp 0", succ_s);
    end
    do_wr(1'b1, 40'h9000, 8'd5);
    checks++;
    if (succ_s !== 1'b1 || entry_vld !== 4'b1101) begin
      errors++; $display("FAIL id5_in_e1: got succ %b vld %b exp 1 1101", succ_s, entry_vld);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_set(40'h1000, 8'd1);
    do_set(40'h2000, 8'd2);
    #3 rst_b = 1'b0;
    #1;
    checks++;
    if (entry_vld !== 4'b0000) begin
      errors++; $display("FAIL async_reset_vld: got %b exp 0000", entry_vld);
    end
    @(negedge clk);
    rst_b = 1'b1;
    do_wr(1'b1, 40'h1000, 8'd1);
    checks++;
    if (succ_s !== 1'b0) begin
      errors++; $display("FAIL post_reset_succ: got %b exp 0", succ_s);
    end
  endtask

  initial begin
    rst_b = 1'b1; icg_en = 1'b0; scan_en = 1'b0;
    set_vld = 1'b0; set_addr = '0; set_id = '0;
    wr_vld = 1'b0; wr_excl = 1'b0; wr_addr = '0; wr_id = '0;
    succ_s = 1'b0;
    test_reset();
    test_excl_success();
    test_nonexcl_clear();
    test_failed_excl();
    test_id_overwrite();
    test_evict();
    test_same_cycle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
